// File: rtl/rat_uart_port.sv
`default_nettype none
// ============================================================================
// Module   : rat_uart_port
// Brief    : RAT CPU I/O-bus UART: TX FIFO + 8N1 serializer, 8N1 receiver
//            with one holding register, and a level interrupt request.
// Revision : 1.0
// ============================================================================
module rat_uart_port #(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         TX_DEPTH     = 4,
    parameter logic [7:0] BASE_ID      = 8'h40
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IO_STRB,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    output logic [7:0] IN_PORT,
    output logic       INT,
    input  logic       RX,
    output logic       TX
);
    localparam int c_ptr_w = $clog2(TX_DEPTH);
    localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_ptr_w:0]   c_full_cnt  = (c_ptr_w + 1)'(TX_DEPTH);
    localparam logic [7:0] c_id_data = BASE_ID;
    localparam logic [7:0] c_id_ctrl = BASE_ID + 8'd1;
    localparam logic [7:0] c_id_ack  = BASE_ID + 8'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

    logic [7:0]         r_fifo_mem [TX_DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr, r_wr_ptr;
    logic [c_ptr_w:0]   r_count;
    logic [1:0]         r_ctrl;
    logic               r_int;
    uart_state_e        r_tx_state, r_rx_state;
    logic [c_cnt_w-1:0] r_tx_cnt, r_rx_cnt;
    logic [2:0]         r_tx_bit, r_rx_bit;
    logic [7:0]         r_tx_shift, r_rx_shift, r_rx_data;
    logic               r_tx;
    logic               r_rx_meta, r_rx_sync;
    logic               r_rx_valid, r_rx_overrun, r_rx_frame_err;

    logic w_wr_data, w_wr_ctrl, w_ack;
    logic w_fifo_empty, w_fifo_full, w_push, w_pop;
    logic w_tx_bit_end, w_tx_empty, w_rx_done;

    assign w_wr_data    = IO_STRB && (PORT_ID == c_id_data);
    assign w_wr_ctrl    = IO_STRB && (PORT_ID == c_id_ctrl);
    assign w_ack        = IO_STRB && (PORT_ID == c_id_ack);
    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == c_full_cnt);
    assign w_push       = w_wr_data && !w_fifo_full;
    assign w_tx_bit_end = (r_tx_cnt == c_bit_last);
    // Pop from IDLE, or straight out of STOP so back-to-back frames have no gap.
    assign w_pop        = !w_fifo_empty &&
                          ((r_tx_state == S_IDLE) || ((r_tx_state == S_STOP) && w_tx_bit_end));
    assign w_tx_empty   = w_fifo_empty && (r_tx_state == S_IDLE);
    assign w_rx_done    = (r_rx_state == S_STOP) && (r_rx_cnt == c_bit_last);

    assign TX  = r_tx;
    assign INT = r_int;

    always_ff @(posedge CLK) begin
        if (w_push) r_fifo_mem[r_wr_ptr] <= OUT_PORT;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_tx_state)
                S_IDLE: if (w_pop) begin
                    r_tx_shift <= r_fifo_mem[r_rd_ptr];
                    r_tx_cnt   <= '0;
                    r_tx_state <= S_START;
                end
                S_START: if (w_tx_bit_end) begin
                    r_tx_cnt   <= '0;
                    r_tx_bit   <= '0;
                    r_tx_state <= S_DATA;
                end else r_tx_cnt <= r_tx_cnt + 1'b1;
                S_DATA: if (w_tx_bit_end) begin
                    r_tx_cnt   <= '0;
                    r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                    if (r_tx_bit == 3'd7) r_tx_state <= S_STOP;
                    else                  r_tx_bit   <= r_tx_bit + 1'b1;
                end else r_tx_cnt <= r_tx_cnt + 1'b1;
                S_STOP: if (w_tx_bit_end) begin
                    r_tx_cnt <= '0;
                    if (w_pop) begin
                        r_tx_shift <= r_fifo_mem[r_rd_ptr];
                        r_tx_state <= S_START;
                    end else r_tx_state <= S_IDLE;
                end else r_tx_cnt <= r_tx_cnt + 1'b1;
                default: r_tx_state <= S_IDLE;
            endcase
            case (r_tx_state)
                S_START: r_tx <= 1'b0;
                S_DATA:  r_tx <= r_tx_shift[0];
                default: r_tx <= 1'b1;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            case (r_rx_state)
                S_IDLE: if (!r_rx_sync) begin
                    r_rx_cnt   <= '0;
                    r_rx_state <= S_START;
                end
                // Mid-start-bit re-sample rejects glitches shorter than half a bit.
                S_START: if (r_rx_cnt == c_half_last) begin
                    r_rx_cnt   <= '0;
                    r_rx_bit   <= '0;
                    r_rx_state <= r_rx_sync ? S_IDLE : S_DATA;
                end else r_rx_cnt <= r_rx_cnt + 1'b1;
                S_DATA: if (r_rx_cnt == c_bit_last) begin
                    r_rx_cnt   <= '0;
                    r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
                    else                  r_rx_bit   <= r_rx_bit + 1'b1;
                end else r_rx_cnt <= r_rx_cnt + 1'b1;
                S_STOP: if (r_rx_cnt == c_bit_last) begin
                    r_rx_cnt   <= '0;
                    r_rx_state <= S_IDLE;
                end else r_rx_cnt <= r_rx_cnt + 1'b1;
                default: r_rx_state <= S_IDLE;
            endcase
        end
    end

    // A delivery coinciding with an acknowledge is treated as landing in an empty holder.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_rx_overrun   <= 1'b0;
            r_rx_frame_err <= 1'b0;
        end else if (w_rx_done && r_rx_sync) begin
            if (!r_rx_valid || w_ack) begin
                r_rx_data  <= r_rx_shift;
                r_rx_valid <= 1'b1;
                if (w_ack) begin
                    r_rx_overrun   <= 1'b0;
                    r_rx_frame_err <= 1'b0;
                end
            end else r_rx_overrun <= 1'b1;
        end else if (w_rx_done) begin
            r_rx_frame_err <= 1'b1;
            if (w_ack) begin
                r_rx_valid   <= 1'b0;
                r_rx_overrun <= 1'b0;
            end
        end else if (w_ack) begin
            r_rx_valid     <= 1'b0;
            r_rx_overrun   <= 1'b0;
            r_rx_frame_err <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ctrl <= '0;
            r_int  <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_ctrl <= OUT_PORT[1:0];
            r_int <= (r_rx_valid & r_ctrl[0]) | (w_tx_empty & r_ctrl[1]);
        end
    end

    always_comb begin
        IN_PORT = 8'h00;
        case (PORT_ID)
            c_id_data: IN_PORT = r_rx_data;
            c_id_ctrl: IN_PORT = {3'b000, r_rx_frame_err, r_rx_overrun, w_fifo_full,
                                  w_tx_empty, r_rx_valid};
            c_id_ack:  IN_PORT = {6'b000000, r_ctrl};
            default:   IN_PORT = 8'h00;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_rat_uart_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_rat_uart_port
// Brief    : Directed scoreboard bench for rat_uart_port (CLKS_PER_BIT = 4).
// Revision : 1.0
// ============================================================================
module tb_rat_uart_port;
    localparam int         CPB   = 4;
    localparam int         FRAME = 10 * CPB;
    localparam logic [7:0] BASE  = 8'h40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       io_strb = 1'b0;
    logic [7:0] port_id = 8'h00;
    logic [7:0] out_port = 8'h00;
    logic [7:0] in_port;
    logic       irq;
    logic       rx = 1'b1;
    logic       tx;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    logic [7:0] burst [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rat_uart_port #(.CLKS_PER_BIT(CPB), .TX_DEPTH(4), .BASE_ID(BASE)) dut (
        .CLK(clk), .RST(rst), .IO_STRB(io_strb), .PORT_ID(port_id), .OUT_PORT(out_port),
        .IN_PORT(in_port), .INT(irq), .RX(rx), .TX(tx)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic io_write(input logic [7:0] id, input logic [7:0] d);
        port_id  = id;
        out_port = d;
        io_strb  = 1'b1;
        @(posedge clk);
        #1;
        io_strb  = 1'b0;
    endtask

    task automatic read_port(input logic [7:0] id, output logic [7:0] v);
        port_id = id;
        #1;
        v = in_port;
    endtask

    task automatic check_read(input string tag, input logic [7:0] id, input logic [7:0] exp);
        logic [7:0] v;
        read_port(id, v);
        check(tag, v, exp);
    endtask

    task automatic check_rx_byte(input string tag);
        logic [7:0] v, e;
        e = 8'hxx;
        if (rx_exp.size() > 0) e = rx_exp.pop_front();
        read_port(BASE, v);
        check(tag, v, e);
    endtask

    function automatic logic [FRAME-1:0] frame_wave(input logic [7:0] b);
        logic [9:0]       f;
        logic [FRAME-1:0] w;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < FRAME; i++) w[i] = f[i / CPB];
        return w;
    endfunction

    // Captures one TX frame cycle-by-cycle from its first low cycle.
    task automatic expect_tx_frame(input string tag, output int t0);
        logic [FRAME-1:0] wave;
        logic [7:0]       b;
        bit               ok;
        wave = '0;
        ok   = 1'b0;
        t0   = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (tx === 1'b0) ok = 1'b1;
        end
        if (ok) begin
            t0 = cyc;
            for (int i = 1; i < FRAME; i++) begin
                @(negedge clk);
                wave[i] = tx;
            end
        end
        check({tag, "_start"}, ok, 1'b1);
        b = 8'hxx;
        if (tx_exp.size() > 0) b = tx_exp.pop_front();
        check(tag, wave, frame_wave(b));
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
        rx = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_prev, t_cur;
        t_prev = 0;
        t_cur  = 0;

        tick(3);
        check("rst_tx", tx, 1'b1);
        check("rst_int", irq, 1'b0);
        check_read("rst_status", BASE + 8'd1, 8'h02);
        check_read("rst_unmapped", BASE + 8'd5, 8'h00);
        check_read("rst_rxdata", BASE, 8'h00);
        check_read("rst_ctrl", BASE + 8'd2, 8'h00);
        rst = 1'b0;
        tick(2);

        // tx_ie alone: INT follows tx_empty one cycle after the control write
        io_write(BASE + 8'd1, 8'hFE);
        check_read("ctrl_read", BASE + 8'd2, 8'h02);
        check("int_tx_lag", irq, 1'b0);
        tick(1);
        check("int_tx_on", irq, 1'b1);
        io_write(BASE + 8'd1, 8'h00);
        tick(1);
        check("int_tx_off", irq, 1'b0);

        // single frame and write-to-start latency
        tx_exp.push_back(8'hA5);
        io_write(BASE, 8'hA5);
        check("tx_lat_n", tx, 1'b1);
        tick(1);
        check("tx_lat_n1", tx, 1'b1);
        check_read("tx_busy_status", BASE + 8'd1, 8'h00);
        tick(1);
        check("tx_lat_n2", tx, 1'b0);
        expect_tx_frame("tx_a5", t_cur);
        tick(1);
        check_read("tx_done_status", BASE + 8'd1, 8'h02);

        // burst: five accepted, sixth dropped while full, frames contiguous
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    tx_exp.push_back(burst[i]);
                    io_write(BASE, burst[i]);
                end
                check_read("burst_full", BASE + 8'd1, 8'h04);
                io_write(BASE, 8'h66);
                check_read("full_after_drop", BASE + 8'd1, 8'h04);
            end
            begin
                for (int k = 0; k < 5; k++) begin
                    expect_tx_frame("tx_burst", t_cur);
                    if (k > 0) check("tx_gap", t_cur - t_prev, FRAME);
                    t_prev = t_cur;
                end
            end
        join
        tick(2 * FRAME);
        check_read("drop_not_sent", BASE + 8'd1, 8'h02);
        check("tx_idle_after_burst", tx, 1'b1);

        // RX delivery, latency, interrupt and acknowledge
        io_write(BASE + 8'd1, 8'h01);
        tick(1);
        rx_exp.push_back(8'h3C);
        send_rx(8'h3C, 1'b1);
        check_read("rx_lat_pre", BASE + 8'd1, 8'h02);
        tick(1);
        check_read("rx_valid", BASE + 8'd1, 8'h03);
        check("int_rx_lag", irq, 1'b0);
        check_rx_byte("rx_data_3c");
        tick(1);
        check("int_rx_on", irq, 1'b1);
        io_write(BASE + 8'd2, 8'h5A);
        check_read("ack_clears", BASE + 8'd1, 8'h02);
        tick(1);
        check("int_rx_off", irq, 1'b0);

        // overrun keeps the old byte
        rx_exp.push_back(8'h3C);
        send_rx(8'h3C, 1'b1);
        tick(1);
        check_read("rx_valid2", BASE + 8'd1, 8'h03);
        check_rx_byte("rx_data_3c_again");
        send_rx(8'h77, 1'b1);
        tick(1);
        check_read("rx_overrun", BASE + 8'd1, 8'h0B);
        check_read("overrun_keeps", BASE, 8'h3C);
        io_write(BASE + 8'd2, 8'h00);
        tick(1);

        // framing error then glitch rejection
        send_rx(8'h55, 1'b0);
        tick(1);
        check_read("rx_frame_err", BASE + 8'd1, 8'h12);
        tick(3 * CPB);
        io_write(BASE + 8'd2, 8'h00);
        check_read("ferr_ack", BASE + 8'd1, 8'h02);
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(FRAME + CPB);
        check_read("glitch_no_byte", BASE + 8'd1, 8'h02);

        // delivery in the same cycle as acknowledge wins
        rx_exp.push_back(8'hC3);
        send_rx(8'hC3, 1'b1);
        tick(1);
        check_rx_byte("rx_data_c3");
        rx_exp.push_back(8'h5A);
        send_rx(8'h5A, 1'b1);
        io_write(BASE + 8'd2, 8'h00);
        check_read("ack_vs_delivery", BASE + 8'd1, 8'h03);
        check_rx_byte("rx_data_5a");
        io_write(BASE + 8'd2, 8'h00);

        // reset mid-TX and mid-RX
        io_write(BASE, 8'h00);
        io_write(BASE, 8'h42);
        rx = 1'b0;
        tick(3 * CPB);
        check("tx_mid_frame", tx, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_async_tx", tx, 1'b1);
        tick(2);
        rx  = 1'b1;
        rst = 1'b0;
        tick(FRAME + 10);
        check_read("rst_flush_status", BASE + 8'd1, 8'h02);
        check("rst_flush_tx", tx, 1'b1);
        check("rst_flush_int", irq, 1'b0);
        check_read("rst_flush_data", BASE, 8'h00);
        check_read("rst_flush_ctrl", BASE + 8'd2, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
